// File: rtl/vend_credit_ctrl_if.sv
// Coin-pulse / credit-status bundle for vend_credit_ctrl.
// master: coin source (debouncer); slave: the credit controller.
interface vend_credit_ctrl_if;
  logic       coin_n;
  logic       coin_d;
  logic       coin_q;
  logic       coin_o;
  logic       refund_req;
  logic [7:0] credit;
  logic       dispense;
  logic       chg_q;
  logic       chg_d;
  logic       chg_n;
  logic       coin_reject;
  logic       busy;

  modport master (
    output coin_n, coin_d, coin_q, coin_o, refund_req,
    input  credit, dispense, chg_q, chg_d, chg_n,
    input  coin_reject, busy
  );

  modport slave (
    input  coin_n, coin_d, coin_q, coin_o, refund_req,
    output credit, dispense, chg_q, chg_d, chg_n,
    output coin_reject, busy
  );
endinterface

// File: rtl/vend_credit_ctrl.sv
// Vending credit controller: accumulates coin credit, auto-vends at PRICE,
// pays change/refund as spaced chg_q/d/n pulses. Ports: clk, rst, bus (slave).
module vend_credit_ctrl #(
  parameter int PRICE   = 65,
  parameter int CHG_GAP = 4
) (
  input logic          clk,
  input logic          rst,
  vend_credit_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ACCEPT,
    DISPENSE,
    CHANGE
  } state_t;

  localparam logic [7:0]  PRICE_C = 8'(PRICE);
  localparam logic [15:0] GAP_M1  = 16'(CHG_GAP - 1);

  state_t      state, state_n;
  logic [7:0]  credit_r, credit_n;
  logic [15:0] gcnt, gcnt_n;
  logic        disp_r, busy_r, rej_r, rej_n;
  logic        q_r, d_r, n_r, q_n, d_n, n_n;
  logic [2:0]  in_cnt;
  logic        any_coin;
  logic        multi;
  logic [7:0]  coin_val;

  assign in_cnt = 3'(bus.coin_n) + 3'(bus.coin_d) + 3'(bus.coin_q)
                + 3'(bus.coin_o) + 3'(bus.refund_req);
  assign multi    = in_cnt > 3'd1;
  assign any_coin = bus.coin_n | bus.coin_d | bus.coin_q | bus.coin_o;

  always_comb begin
    coin_val = 8'd0;
    if (in_cnt == 3'd1) begin
      unique case (1'b1)
        bus.coin_n: coin_val = 8'd5;
        bus.coin_d: coin_val = 8'd10;
        bus.coin_q: coin_val = 8'd25;
        bus.coin_o: coin_val = 8'd100;
        default:    coin_val = 8'd0;
      endcase
    end
  end

  always_comb begin
    state_n  = state;
    credit_n = credit_r;
    gcnt_n   = gcnt;
    rej_n    = 1'b0;
    q_n      = 1'b0;
    d_n      = 1'b0;
    n_n      = 1'b0;
    unique case (state)
      ACCEPT: begin
        if (multi) begin
          rej_n = 1'b1;
        end else if (any_coin) begin
          credit_n = credit_r + coin_val;
          if (credit_n >= PRICE_C) state_n = DISPENSE;
        end else if (bus.refund_req && credit_r != 8'd0) begin
          state_n = CHANGE;
          gcnt_n  = '0;
        end
      end
      DISPENSE: begin
        rej_n    = any_coin;
        credit_n = credit_r - PRICE_C;
        gcnt_n   = '0;
        state_n  = (credit_n != 8'd0) ? CHANGE : ACCEPT;
      end
      CHANGE: begin
        rej_n = any_coin;
        if (credit_r == 8'd0) begin
          state_n = ACCEPT;
        end else if (gcnt == 16'd0) begin
          gcnt_n = GAP_M1;
          // Greedy: credit is a multiple of 5, so this ends at 0.
          if (credit_r >= 8'd25) begin
            q_n      = 1'b1;
            credit_n = credit_r - 8'd25;
          end else if (credit_r >= 8'd10) begin
            d_n      = 1'b1;
            credit_n = credit_r - 8'd10;
          end else begin
            n_n      = 1'b1;
            credit_n = credit_r - 8'd5;
          end
        end else begin
          gcnt_n = gcnt - 16'd1;
        end
      end
      default: state_n = ACCEPT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ACCEPT;
      credit_r <= '0;
      gcnt     <= '0;
      disp_r   <= 1'b0;
      busy_r   <= 1'b0;
      rej_r    <= 1'b0;
      q_r      <= 1'b0;
      d_r      <= 1'b0;
      n_r      <= 1'b0;
    end else begin
      state    <= state_n;
      credit_r <= credit_n;
      gcnt     <= gcnt_n;
      // Outputs decode the next state so they align with it.
      disp_r   <= state_n == DISPENSE;
      busy_r   <= state_n != ACCEPT;
      rej_r    <= rej_n;
      q_r      <= q_n;
      d_r      <= d_n;
      n_r      <= n_n;
    end
  end

  assign bus.credit      = credit_r;
  assign bus.dispense    = disp_r;
  assign bus.busy        = busy_r;
  assign bus.coin_reject = rej_r;
  assign bus.chg_q       = q_r;
  assign bus.chg_d       = d_r;
  assign bus.chg_n       = n_r;

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Directed bench for vend_credit_ctrl: table of per-cycle vectors on two
// instances (65/4 and 5/1) plus an asynchronous mid-change reset sequence.
module tb_vend_credit_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  vend_credit_ctrl_if ba ();
  vend_credit_ctrl_if bb ();

  vend_credit_ctrl #(.PRICE(65), .CHG_GAP(4)) dut_a (
    .clk(clk), .rst(rst), .bus(ba.slave)
  );

  vend_credit_ctrl #(.PRICE(5), .CHG_GAP(1)) dut_b (
    .clk(clk), .rst(rst), .bus(bb.slave)
  );

  // inputs {refund, o, q, d, n}
  localparam logic [4:0] I0 = 5'b00000;
  localparam logic [4:0] IN = 5'b00001;
  localparam logic [4:0] ID = 5'b00010;
  localparam logic [4:0] IQ = 5'b00100;
  localparam logic [4:0] IO = 5'b01000;
  localparam logic [4:0] IR = 5'b10000;
  // flags {busy, dispense, reject, chg_q, chg_d, chg_n}
  localparam logic [5:0] F0 = 6'b000000;
  localparam logic [5:0] B  = 6'b100000;
  localparam logic [5:0] DS = 6'b010000;
  localparam logic [5:0] RJ = 6'b001000;
  localparam logic [5:0] CQ = 6'b000100;
  localparam logic [5:0] CD = 6'b000010;
  localparam logic [5:0] CN = 6'b000001;

  typedef struct packed {
    logic       sel_b;
    logic [4:0] in;
    logic [7:0] cr;
    logic [5:0] fl;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(logic s, logic [4:0] i,
                              logic [7:0] c, logic [5:0] f);
    vec_t v;
    v.sel_b = s;
    v.in    = i;
    v.cr    = c;
    v.fl    = f;
    vq.push_back(v);
  endfunction

  function automatic logic [5:0] flags_a();
    return {ba.busy, ba.dispense, ba.coin_reject,
            ba.chg_q, ba.chg_d, ba.chg_n};
  endfunction

  function automatic logic [5:0] flags_b();
    return {bb.busy, bb.dispense, bb.coin_reject,
            bb.chg_q, bb.chg_d, bb.chg_n};
  endfunction

  task automatic drive(logic s, logic [4:0] i);
    {ba.refund_req, ba.coin_o, ba.coin_q, ba.coin_d, ba.coin_n} =
      s ? 5'b0 : i;
    {bb.refund_req, bb.coin_o, bb.coin_q, bb.coin_d, bb.coin_n} =
      s ? i : 5'b0;
  endtask

  task automatic chk8(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk6(string nm, logic [5:0] act, logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  initial begin
    logic seen;
    drive(1'b0, I0);
    drive(1'b1, I0);

    // exact payment
    add(0, IQ, 8'd25, F0);
    for (int k = 0; k < 9; k++) add(0, I0, 8'd25, F0);
    add(0, IQ, 8'd50, F0);
    for (int k = 0; k < 9; k++) add(0, I0, 8'd50, F0);
    add(0, ID, 8'd60, F0);
    for (int k = 0; k < 9; k++) add(0, I0, 8'd60, F0);
    add(0, IN, 8'd65, B | DS);
    for (int k = 0; k < 4; k++) add(0, I0, 8'd0, F0);
    // overpayment with a dollar
    add(0, IO, 8'd100, B | DS);
    add(0, I0, 8'd35, B);
    add(0, I0, 8'd10, B | CQ);
    add(0, I0, 8'd10, B);
    add(0, I0, 8'd10, B);
    add(0, I0, 8'd10, B);
    add(0, I0, 8'd0, B | CD);
    add(0, I0, 8'd0, F0);
    add(0, I0, 8'd0, F0);
    // refund
    add(0, IQ, 8'd25, F0);
    add(0, IN, 8'd30, F0);
    add(0, IR, 8'd30, B);
    add(0, I0, 8'd5, B | CQ);
    add(0, I0, 8'd5, B);
    add(0, I0, 8'd5, B);
    add(0, I0, 8'd5, B);
    add(0, I0, 8'd0, B | CN);
    add(0, I0, 8'd0, F0);
    add(0, IR, 8'd0, F0);
    // rejects: double coin in ACCEPT, coins in DISPENSE/CHANGE
    add(0, IQ | IN, 8'd0, RJ);
    add(0, I0, 8'd0, F0);
    add(0, IO, 8'd100, B | DS);
    add(0, IN, 8'd35, B | RJ);
    add(0, ID, 8'd10, B | CQ | RJ);
    add(0, I0, 8'd10, B);
    add(0, I0, 8'd10, B);
    add(0, I0, 8'd10, B);
    add(0, I0, 8'd0, B | CD);
    add(0, I0, 8'd0, F0);
    // PRICE=5, CHG_GAP=1: 95 paid back-to-back
    add(1, IO, 8'd100, B | DS);
    add(1, I0, 8'd95, B);
    add(1, I0, 8'd70, B | CQ);
    add(1, I0, 8'd45, B | CQ);
    add(1, I0, 8'd20, B | CQ);
    add(1, I0, 8'd10, B | CD);
    add(1, I0, 8'd0, B | CD);
    add(1, I0, 8'd0, F0);

    #1;
    chk8("reset credit", ba.credit, 8'd0);
    chk6("reset flags", flags_a(), F0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i].sel_b, vq[i].in);
      @(negedge clk);
      if (vq[i].sel_b) begin
        chk8($sformatf("row%0d credit_b", i), bb.credit, vq[i].cr);
        chk6($sformatf("row%0d flags_b", i), flags_b(), vq[i].fl);
      end else begin
        chk8($sformatf("row%0d credit_a", i), ba.credit, vq[i].cr);
        chk6($sformatf("row%0d flags_a", i), flags_a(), vq[i].fl);
      end
    end
    drive(1'b0, I0);

    // asynchronous reset between chg_q and chg_d
    drive(1'b0, IO);
    @(negedge clk);
    drive(1'b0, I0);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = ba.chg_q;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rst_seq chg_q: got none expected pulse");
    end
    #2 rst = 1'b1;
    #1;
    chk8("async rst credit", ba.credit, 8'd0);
    chk6("async rst flags", flags_a(), F0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ba.chg_d || ba.busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL post-rst quiet: got activity expected none");
    end
    drive(1'b0, IQ);
    @(negedge clk);
    drive(1'b0, I0);
    chk8("post-rst credit", ba.credit, 8'd25);
    chk6("post-rst flags", flags_a(), F0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_credit_ctrl.md
# vend_credit_ctrl

Vending-machine credit controller that sits directly downstream of the coin-input debouncer. It consumes the debouncer's single-cycle, one-hot pulses: nickel, dime, quarter, dollar and coin-return. It accumulates credit in cents, auto-vends when credit reaches the price, and pays change or a refund as spaced single-cycle coin-eject pulses.

## Interface
- PRICE, 65: item price in cents; a multiple of 5, range 5..155.
- CHG_GAP, 4: cycles between successive change-coin pulses; range 1..65535.
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- coin_n  in  1  nickel pulse, 5 c.
- coin_d  in  1  dime pulse, 10 c.
- coin_q  in  1  quarter pulse, 25 c.
- coin_o  in  1  dollar pulse, 100 c.
- refund_req  in  1  coin-return pulse; all credit is returned as change.
- credit  out  8  current credit in cents, unsigned.
- dispense  out  1  one-cycle vend pulse.
- chg_q, chg_d, chg_n  out  1 each  one-cycle change-coin eject pulses.
- coin_reject  out  1  one-cycle pulse: the inserted coin is diverted to the return chute and not credited.
- busy  out  1  high whenever state is not ACCEPT.

## Operation
- States: ACCEPT, DISPENSE, CHANGE.
- Input validity: an input cycle is valid when exactly one of coin_n/d/q/o/refund_req is high.
  - Cycles with more than one input high are invalid.
  - An invalid cycle is ignored except for a coin_reject pulse.
- ACCEPT behaviour:
  - Valid coin: credit <= credit + value.
  - If the new credit >= PRICE, go to DISPENSE; otherwise stay in ACCEPT.
  - refund_req with credit > 0: go to CHANGE.
  - refund_req with credit == 0: no effect.
- DISPENSE behaviour:
  - Lasts exactly one cycle.
  - credit <= credit - PRICE.
  - Next state is CHANGE if the remainder is > 0, else ACCEPT.
- CHANGE behaviour, using a 16-bit gap counter (gcnt) that is cleared on entry:
  - If credit == 0: go to ACCEPT.
  - Else if gcnt == 0: issue the largest coin <= credit (25, then 10, then 5) and subtract its value; gcnt <= CHG_GAP-1.
  - Else: gcnt <= gcnt-1.
- Coins in DISPENSE or CHANGE: never credited; each produces a coin_reject pulse. refund_req in DISPENSE or CHANGE is ignored.
- Credit bounds: maximum credit is PRICE-5+100 <= 250, so the 8-bit width never wraps. Credit is always a multiple of 5, so greedy change always ends at exactly 0.
- Reset effects:
  - State goes to ACCEPT and gcnt to 0.
  - All outputs go to 0: credit, dispense, chg_q/d/n, coin_reject, busy.
  - Reset mid-CHANGE discards any unpaid change; no further pulses are issued.

## Timing
- All outputs are registered; none are combinational from the inputs.
- Coin pulse sampled at edge t:
  - credit shows the new value after edge t.
  - If the vend threshold is crossed, dispense is high for the cycle after edge t, and busy rises at the same edge.
- Credit after the vend: updated to credit-PRICE at the edge ending DISPENSE.
- First change pulse: the cycle after the edge that enters CHANGE plus one decision edge, i.e. 2 cycles after dispense.
- Later change pulses: spaced exactly CHG_GAP cycles apart. With CHG_GAP=1 they are back-to-back.
- credit decrements at the same edge that raises the corresponding chg_* pulse.
- Return to ACCEPT: busy falls one edge after the final change pulse, the first edge that sees credit == 0.
- coin_reject timing: high for the cycle after the offending input edge.
- Pulse exclusivity: at most one of chg_q/chg_d/chg_n is high in any cycle, and none is ever high for 2 consecutive cycles when CHG_GAP > 1.

## Test plan
- Exact payment (PRICE=65, CHG_GAP=4): Q, Q, D, N pulses spaced 10 cycles.
  - credit steps 25→50→60→65.
  - One dispense pulse.
  - credit reads 0 afterwards, with no chg_* pulses.
- Overpayment: a single coin_o pulse.
  - dispense, then chg_q, then chg_d 4 cycles later.
  - credit ends at 0; busy falls.
- Refund: Q, N, then refund_req.
  - chg_q then chg_n, 4 cycles apart; credit ends at 0.
  - No dispense.
- Rejects during change: a coin_d pulse during CHANGE, and a cycle with coin_q and coin_n high together in ACCEPT.
  - Each gives one coin_reject pulse.
  - credit is unaffected.
- Reset mid-operation: after coin_o, assert rst asynchronously (not on an edge) between the chg_q and chg_d pulses.
  - All outputs 0 immediately.
  - No chg_d afterwards.
  - State is ACCEPT and a new coin is credited normally.
- CHG_GAP=1 with PRICE=5, then a coin_o pulse.
  - Change of 95 paid as Q, Q, Q, D, D on 5 consecutive cycles.
